des3_pass_sequencer: RTL

Sequences one 64-bit block through the 6-round unrolled 3DES core: accepts a block over a valid/ready handshake, steps the 2-bit round-key group select and key-bank select through all passes, recirculates the core output into a state register each pass, and presents the result over a second valid/ready handshake. It sits between the block input FIFO and the output stage. It drives the round-key group selector that slices 6 × 48-bit keys from a 1152-bit key bank. It also locks the key schedule while a block is in flight.

---
 rtl/des3_pkg.sv | 8 +
 rtl/des3_pass_counter.sv | 17 +
 rtl/des3_pass_sequencer.sv | 66 ++++++
 3 files changed

// File: rtl/des3_pkg.sv
// des3_pkg: shared state encoding and DES geometry constants for the pass sequencer.
package des3_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int DES_BLOCK_W     = 64;
    localparam int ROUNDS_PER_PASS = 6;
    localparam int KEY_W           = 48;
    localparam int KEYS_PER_BANK   = 24;
endpackage

// File: rtl/des3_pass_counter.sv
// des3_pass_counter: 3-bit pass index with clear/enable and terminal-count flag.
module des3_pass_counter #(
    parameter int NUM_PASSES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    output logic [2:0] q,
    output logic       tc
);
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= '0;
        else if (clr) q <= '0;
        else if (en) q <= q + 3'd1;
    assign tc = q == 3'(NUM_PASSES - 1);
endmodule

// File: rtl/des3_pass_sequencer.sv
// des3_pass_sequencer: steps one block through all passes of the unrolled 3DES core.
module des3_pass_sequencer
    import des3_pkg::*;
#(
    parameter int BLOCK_W    = 64,
    parameter int NUM_PASSES = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    input  logic               keys_valid,
    output logic               key_lock,
    output logic [1:0]         count,
    output logic               bank_sel,
    output logic [BLOCK_W-1:0] dp_in,
    input  logic [BLOCK_W-1:0] dp_out,
    output logic               dp_first,
    output logic               dp_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic [15:0]        blocks_done
);
    state_t             state;
    logic [BLOCK_W-1:0] state_q;
    logic [2:0]         pass_idx;
    logic               tc, run, done, accept;
    assign run       = state == RUN;
    assign done      = state == DONE;
    assign in_ready  = keys_valid && (state == IDLE || (done && out_ready));
    assign accept    = in_valid && in_ready;
    assign key_lock  = state != IDLE;
    assign out_valid = done;
    assign out_data  = done ? state_q : '0;
    assign dp_in     = run ? state_q : '0;
    assign count     = run ? pass_idx[1:0] : 2'd0;
    // Single-DES configurations never leave bank 0.
    assign bank_sel  = run && NUM_PASSES == 8 && pass_idx[2];
    assign dp_first  = run && pass_idx == 3'd0;
    assign dp_last   = run && tc;
    des3_pass_counter #(.NUM_PASSES(NUM_PASSES)) u_cnt (
        .clk(clk),
        .rst(rst),
        .clr(accept || (run && tc)),
        .en (run),
        .q  (pass_idx),
        .tc (tc)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state       <= IDLE;
            state_q     <= '0;
            blocks_done <= '0;
        end else begin
            if (accept) begin
                state   <= RUN;
                state_q <= in_data;
            end else if (run) begin
                state_q <= dp_out;
                if (tc) state <= DONE;
            end else if (done && out_ready) state <= IDLE;
            if (done && out_ready) blocks_done <= blocks_done + 16'd1;
        end
endmodule
